branch_pc_ctrl: RTL and testbench



---
 rtl/branch_pc_ctrl.sv | 126 ++++++++++++
 tb/tb_branch_pc_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: next-fetch PC with conditional jump/call/return and a return stack.
// Define STACK_OVERWRITE_EN to let a call on a full stack evict the oldest entry.
module branch_pc_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int PC_STEP     = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   op,
  input  logic                         cond_result,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         clr_flags,
  output logic [ADDR_W-1:0]            pc,
  output logic                         branch_taken,
  output logic [$clog2(STACK_DEPTH):0] stack_count,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;

`ifdef STACK_OVERWRITE_EN
  localparam logic OVW = 1'b1;
`else
  localparam logic OVW = 1'b0;
`endif

  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic [ADDR_W-1:0] r_pc;
  logic              r_bt;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_wp;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_stk [STACK_DEPTH];

  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_jmp;
  logic              w_call;
  logic              w_ret;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [PW-1:0]     w_top;
  logic [PW-1:0]     w_wp_inc;

  assign w_seq   = r_pc + ADDR_W'(PC_STEP);
  assign w_full  = (r_cnt == CW'(STACK_DEPTH));
  assign w_empty = (r_cnt == '0);

  assign w_jmp  = en & cond_result & (op == OP_JMP);
  assign w_call = en & cond_result & (op == OP_CALL);
  assign w_ret  = en & cond_result & (op == OP_RET);

  // A full-stack call only pushes when eviction of the oldest is allowed.
  assign w_push    = w_call & (~w_full | OVW);
  assign w_pop     = w_ret & ~w_empty;
  assign w_ovf_set = w_call & w_full;
  assign w_unf_set = w_ret & w_empty;

  // r_wp is the next free slot; the ring wraps so a full push lands on the oldest.
  assign w_top    = (r_wp == '0) ? PW'(STACK_DEPTH - 1) : r_wp - 1'b1;
  assign w_wp_inc = (r_wp == PW'(STACK_DEPTH - 1)) ? '0 : r_wp + 1'b1;

  // Select the next fetch address.
  always_comb begin
    w_pc_nxt = w_seq;
    unique case (1'b1)
      w_jmp, w_push: w_pc_nxt = target;
      w_pop:         w_pc_nxt = r_stk[w_top];
      default:       w_pc_nxt = w_seq;
    endcase
  end

  // PC, branch pulse and stack bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_bt  <= 1'b0;
      r_cnt <= '0;
      r_wp  <= '0;
    end else begin
      r_bt <= w_jmp | w_push | w_pop;
      if (en) r_pc <= w_pc_nxt;
      if (w_push) r_wp <= w_wp_inc;
      else if (w_pop) r_wp <= w_top;
      if (w_push & ~w_full) r_cnt <= r_cnt + 1'b1;
      else if (w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (clr_flags) r_ovf <= 1'b0;
      if (w_unf_set) r_unf <= 1'b1;
      else if (clr_flags) r_unf <= 1'b0;
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_stk[r_wp] <= w_seq;
  end

  assign pc              = r_pc;
  assign branch_taken    = r_bt;
  assign stack_count     = r_cnt;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Testbench for branch_pc_ctrl: vector table, corner sequences, random vs model.
// Honours STACK_OVERWRITE_EN when it is defined for the build.
module tb_branch_pc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] op = 2'd0;
  logic       cond_result = 1'b0;
  logic [7:0] target = 8'h00;
  logic       clr_flags = 1'b0;
  logic [7:0] pc;
  logic       branch_taken;
  logic [2:0] stack_count;
  logic       stack_overflow;
  logic       stack_underflow;

  int n_vec = 0;
  int n_err = 0;

  branch_pc_ctrl #(.ADDR_W(8), .PC_STEP(4), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op),
    .cond_result(cond_result), .target(target), .clr_flags(clr_flags),
    .pc(pc), .branch_taken(branch_taken), .stack_count(stack_count),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue is the stack, back is the top.
  logic [7:0] m_pc;
  logic [7:0] m_q[$];
  bit         m_bt, m_ovf, m_unf;

  task automatic m_reset();
    m_pc = 8'h00;
    m_q.delete();
    m_bt = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic m_step(bit e, logic [1:0] o, bit c, logic [7:0] t, bit cl);
    int seq;
    bit ov, un;
    seq = (int'(m_pc) + 4) % 256;
    ov = 1'b0;
    un = 1'b0;
    m_bt = 1'b0;
    if (e) begin
      case (o)
        2'd0: m_pc = 8'(seq);
        2'd1: if (c) begin m_pc = t; m_bt = 1'b1; end else m_pc = 8'(seq);
        2'd2: begin
          if (!c) m_pc = 8'(seq);
          else if (m_q.size() < 4) begin
            m_q.push_back(8'(seq)); m_pc = t; m_bt = 1'b1;
          end else begin
            ov = 1'b1;
`ifdef STACK_OVERWRITE_EN
            void'(m_q.pop_front());
            m_q.push_back(8'(seq)); m_pc = t; m_bt = 1'b1;
`else
            m_pc = 8'(seq);
`endif
          end
        end
        default: begin
          if (!c) m_pc = 8'(seq);
          else if (m_q.size() > 0) begin
            m_pc = m_q.pop_back(); m_bt = 1'b1;
          end else begin
            un = 1'b1; m_pc = 8'(seq);
          end
        end
      endcase
    end
    if (cl) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (ov) m_ovf = 1'b1;
    if (un) m_unf = 1'b1;
  endtask

  task automatic chk(string nm, logic [7:0] ep, bit eb, logic [2:0] ec,
                     bit eo, bit eu);
    n_vec++;
    if (pc !== ep || branch_taken !== eb || stack_count !== ec ||
        stack_overflow !== eo || stack_underflow !== eu) begin
      n_err++;
      $display("FAIL %s: got pc=%h bt=%b cnt=%0d ovf=%b unf=%b, want pc=%h bt=%b cnt=%0d ovf=%b unf=%b",
               nm, pc, branch_taken, stack_count, stack_overflow,
               stack_underflow, ep, eb, ec, eo, eu);
    end
  endtask

  task automatic chk_model(string nm);
    chk(nm, m_pc, m_bt, 3'(m_q.size()), m_ovf, m_unf);
  endtask

  task automatic step(bit e, logic [1:0] o, bit c, logic [7:0] t, bit cl);
    en = e; op = o; cond_result = c; target = t; clr_flags = cl;
    m_step(e, o, c, t, cl);
    @(posedge clk);
    #1;
  endtask

  // Reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(string nm);
    rst_n = 1'b0;
    #1;
    chk(nm, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit en; logic [1:0] op; bit c; logic [7:0] t; bit clr;
    logic [7:0] pc; bit bt; logic [2:0] cnt; bit ov; bit un;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit e, logic [1:0] o, bit c, logic [7:0] t,
                              bit cl, logic [7:0] p, bit b, logic [2:0] n,
                              bit ov, bit un);
    vec_t v;
    v.en = e; v.op = o; v.c = c; v.t = t; v.clr = cl;
    v.pc = p; v.bt = b; v.cnt = n; v.ov = ov; v.un = un;
    return v;
  endfunction

  logic [7:0] ovf_pc5;
  bit         ovf_bt5;
  logic [7:0] ret_pc[5];

  initial begin
    tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 1'b0, 8'h40, 1'b0, 8'h0C, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 1'b1, 8'h40, 1'b0, 8'h40, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'h44, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd2, 1'b1, 8'h80, 1'b0, 8'h80, 1'b1, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd3, 1'b1, 8'h00, 1'b0, 8'h14, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd3, 1'b1, 8'h00, 1'b0, 8'h18, 1'b0, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 2'd3, 1'b1, 8'h00, 1'b1, 8'h1C, 1'b0, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h1C, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd1, 1'b1, 8'h99, 1'b0, 8'h1C, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 1'b1, 8'h1C, 1'b0, 8'h1C, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd2, 1'b0, 8'h50, 1'b0, 8'h20, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 8'h24, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 1'b1, 8'h77, 1'b0, 8'h28, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd2, 1'b1, 8'hF0, 1'b0, 8'hF0, 1'b1, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hF4, 1'b0, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hF8, 1'b0, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFC, 1'b0, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd3, 1'b1, 8'h00, 1'b0, 8'h2C, 1'b1, 3'd0, 1'b0, 1'b0));

`ifdef STACK_OVERWRITE_EN
    ovf_pc5 = 8'h50; ovf_bt5 = 1'b1;
    ret_pc[0] = 8'h44; ret_pc[1] = 8'h34; ret_pc[2] = 8'h24;
    ret_pc[3] = 8'h14; ret_pc[4] = 8'h18;
`else
    ovf_pc5 = 8'h44; ovf_bt5 = 1'b0;
    ret_pc[0] = 8'h34; ret_pc[1] = 8'h24; ret_pc[2] = 8'h14;
    ret_pc[3] = 8'h04; ret_pc[4] = 8'h08;
`endif

    // Power-on reset.
    m_reset();
    #2;
    chk("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential flow across the 8-bit wrap.
    for (int i = 0; i < 65; i++) begin
      step(1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
      chk("seq_wrap", 8'(((i + 1) * 4) % 256), 1'b0, 3'd0, 1'b0, 1'b0);
    end

    // Directed vector table.
    do_reset("reset_tbl");
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].op, tbl[i].c, tbl[i].t, tbl[i].clr);
      chk($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].bt, tbl[i].cnt,
          tbl[i].ov, tbl[i].un);
    end

    // Fill the stack, overflow it, then drain past empty.
    do_reset("reset_ovf");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd2, 1'b1, 8'((i + 1) * 16), 1'b0);
      chk("fill", 8'((i + 1) * 16), 1'b1, 3'(i + 1), 1'b0, 1'b0);
    end
    step(1'b1, 2'd2, 1'b1, 8'h50, 1'b0);
    chk("call_full", ovf_pc5, ovf_bt5, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd3, 1'b1, 8'h00, 1'b0);
      chk("drain", ret_pc[i], 1'b1, 3'(3 - i), 1'b1, 1'b0);
    end
    step(1'b1, 2'd3, 1'b1, 8'h00, 1'b0);
    chk("ret_empty", ret_pc[4], 1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b1, 2'd0, 1'b0, 8'h00, 1'b1);
    chk("clr_both", 8'(int'(ret_pc[4]) + 4), 1'b0, 3'd0, 1'b0, 1'b0);

    // Mid-sequence async reset, then stalls.
    step(1'b1, 2'd2, 1'b1, 8'hA0, 1'b0);
    chk_model("pre_rst");
    step(1'b1, 2'd3, 1'b1, 8'h00, 1'b0);
    step(1'b1, 2'd3, 1'b1, 8'h00, 1'b0);
    chk_model("pre_rst_unf");
    do_reset("async_rst");
    step(1'b0, 2'd1, 1'b1, 8'h33, 1'b0);
    chk("stall0", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
    chk("post_rst", 8'h04, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 8'h60, 1'b0);
    step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
    chk("stall_bt", 8'h60, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 2'd2, 1'b1, 8'h70, 1'b0);
    chk("stall1", 8'h60, 1'b0, 3'd0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(9) != 0), 2'($urandom_range(3)),
           ($urandom_range(3) != 0), 8'($urandom),
           ($urandom_range(9) == 0));
      chk_model("rand");
      if ($urandom_range(499) == 0) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
